eaglesong_absorb_stream: RTL and testbench

//  Streaming, sequential front end of the Eaglesong sponge. Accepts a message as byte beats (valid/ready).

---
 rtl/eaglesong_absorb_stream.sv | 114 +++++++++++
 tb/tb_eaglesong_absorb_stream.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eaglesong_absorb_stream.sv
// eaglesong_absorb_stream: packs message byte beats into Eaglesong rate blocks with delimiter padding
// and hands each finished block to the absorb stage over valid/ready.
module eaglesong_absorb_stream #(
   parameter int         RATE_WORDS = 8,
   parameter int         IN_BYTES   = 4,
   parameter logic [7:0] DELIMITER  = 8'h06
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [8*IN_BYTES-1:0]          in_data,
   input  logic [$clog2(IN_BYTES+1)-1:0]  in_nbytes,
   input  logic                           in_last,
   output logic                           blk_valid,
   input  logic                           blk_ready,
   output logic [32*RATE_WORDS-1:0]       blk_words,
   output logic                           blk_first,
   output logic                           blk_last,
   output logic                           err
);
   localparam int RB = 4*RATE_WORDS;
   localparam int CW = $clog2(RB+1);
   localparam int NW = $clog2(IN_BYTES+1);

   typedef enum logic [1:0] {S_FILL, S_HOLD, S_PAD} state_t;

   state_t        r_state;
   logic [7:0]    r_buf [RB];
   logic [CW-1:0] r_cnt;
   logic          r_pend, r_first, r_blk_first, r_blk_last, r_err;
   logic [7:0]    w_buf_n [RB];
   logic [CW-1:0] w_cnt_n;
   logic          w_take, w_bad, w_load, w_dlm, w_clr, w_pad, w_done;

   assign in_ready  = r_state == S_FILL;
   assign blk_valid = r_state == S_HOLD;
   assign blk_first = r_blk_first;
   assign blk_last  = r_blk_last;
   assign err       = r_err;

   assign w_take  = in_valid && in_ready;
   assign w_bad   = in_nbytes > NW'(IN_BYTES) || (!in_last && in_nbytes != NW'(IN_BYTES));
   assign w_load  = w_take && !w_bad;
   assign w_cnt_n = r_cnt + CW'(in_nbytes);
   assign w_done  = in_last || w_cnt_n == CW'(RB);
   assign w_dlm   = w_load && in_last && w_cnt_n < CW'(RB);
   assign w_clr   = blk_valid && blk_ready;
   assign w_pad   = r_state == S_PAD;

   // Byte buffer next state: data lands at byte_cnt onward, delimiter right after the last data byte.
   always_comb begin
      w_buf_n = r_buf;
      for (int p = 0; p < RB; p++) begin
         for (int b = 0; b < IN_BYTES; b++)
            if (p >= b && w_load && b < int'(in_nbytes) && int'(r_cnt) == p - b) w_buf_n[p] = in_data[8*b +: 8];
         if (w_dlm && int'(w_cnt_n) == p) w_buf_n[p] = DELIMITER;
         if (w_clr) w_buf_n[p] = 8'h00;
         if (w_pad && p == 0) w_buf_n[p] = DELIMITER;
      end
   end

   // Only present bytes shift into a word, so a partially filled word is right-aligned.
   always_comb begin
      blk_words = '0;
      for (int w = 0; w < RATE_WORDS; w++)
         blk_words[32*w +: 32] = {r_buf[4*w], r_buf[4*w+1], r_buf[4*w+2], r_buf[4*w+3]} >>
            (r_cnt >= CW'(4*w+4) ? 0 : r_cnt <= CW'(4*w) ? 32 : 8*(4*w+4-int'(r_cnt)));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_FILL;
         r_cnt       <= '0;
         r_pend      <= 1'b0;
         r_first     <= 1'b1;
         r_blk_first <= 1'b0;
         r_blk_last  <= 1'b0;
         r_err       <= 1'b0;
         for (int p = 0; p < RB; p++) r_buf[p] <= 8'h00;
      end else begin
         r_buf <= w_buf_n;
         case (r_state)
            S_FILL: if (w_take) begin
               if (w_bad) r_err <= 1'b1;
               else begin
                  if (r_cnt == '0) r_blk_first <= r_first;
                  r_cnt <= w_dlm ? w_cnt_n + CW'(1) : w_cnt_n;
                  if (w_done) begin
                     r_state    <= S_HOLD;
                     r_blk_last <= w_dlm;
                     r_pend     <= in_last && !w_dlm;
                  end
               end
            end
            S_HOLD: if (blk_ready) begin
               r_state     <= r_pend ? S_PAD : S_FILL;
               r_cnt       <= '0;
               r_first     <= r_blk_last;
               r_blk_first <= 1'b0;
               r_blk_last  <= 1'b0;
            end
            S_PAD: begin
               r_state     <= S_HOLD;
               r_cnt       <= CW'(1);
               r_pend      <= 1'b0;
               r_blk_first <= 1'b0;
               r_blk_last  <= 1'b1;
            end
            default: r_state <= S_FILL;
         endcase
      end
   end
endmodule

// File: tb/tb_eaglesong_absorb_stream.sv
// tb_eaglesong_absorb_stream: random message stream against a byte-stream padding model,
// with directed vectors, backpressure, protocol errors and async reset.
module tb_eaglesong_absorb_stream;
   localparam int RW = 8;
   localparam int IB = 4;
   localparam int RB = 4*RW;

   logic            clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, in_last = 1'b0, blk_ready = 1'b0;
   logic [8*IB-1:0] in_data = '0;
   logic [2:0]      in_nbytes = '0;
   logic            in_ready, blk_valid, blk_first, blk_last, err;
   logic [32*RW-1:0] blk_words;

   typedef struct {logic [32*RW-1:0] w; logic f; logic l;} blk_t;
   blk_t        q[$];
   logic [7:0]  msg[$];
   int          total = 0, bad = 0, rdy_mode = 0;
   logic [32*RW-1:0] hold_w;

   eaglesong_absorb_stream #(.RATE_WORDS(RW), .IN_BYTES(IB), .DELIMITER(8'h06)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_nbytes(in_nbytes), .in_last(in_last), .blk_valid(blk_valid), .blk_ready(blk_ready),
      .blk_words(blk_words), .blk_first(blk_first), .blk_last(blk_last), .err(err));

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [32*RW-1:0] act, input logic [32*RW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Stream view: message ++ delimiter cut into RB-byte blocks; absent bytes never shift into a word.
   function automatic void model();
      int n = msg.size();
      int nb = n / RB + 1;
      blk_t b;
      logic [31:0] word;
      for (int j = 0; j < nb; j++) begin
         b.w = '0;
         for (int w = 0; w < RW; w++) begin
            word = '0;
            for (int k = 0; k < 4; k++) begin
               int p = j*RB + 4*w + k;
               if (p < n) word = {word[23:0], msg[p]};
               else if (p == n) word = {word[23:0], 8'h06};
            end
            b.w[32*w +: 32] = word;
         end
         b.f = j == 0;
         b.l = j == nb - 1;
         q.push_back(b);
      end
   endfunction

   task automatic load_hello();
      string s = "Hello, world!\n";
      msg.delete();
      for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
   endtask

   task automatic beat(input logic [31:0] d, input logic [2:0] nb, input logic l);
      int t = 0;
      in_valid = 1'b1; in_data = d; in_nbytes = nb; in_last = l;
      while (!in_ready && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 2000) begin
         total++; bad++;
         $display("FAIL beat_wait: in_ready stuck at %0b for %0d cycles, need 1", in_ready, t);
      end
      @(negedge clk);
   endtask

   task automatic send(input int maxb, input bit inj);
      int n = msg.size();
      int nb = n == 0 ? 1 : (n + IB - 1) / IB;
      int ik = $urandom_range(0, nb - 1);
      int rem;
      logic [31:0] d;
      for (int k = 0; k < nb && k < maxb; k++) begin
         if (inj && k == ik) begin
            int r = $urandom_range(0, 6);
            beat($urandom, r < 4 ? 3'(r) : 3'(r + 1), 1'b0);
         end
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
         rem = n - k*IB;
         d = $urandom;
         for (int i = 0; i < IB && i < rem; i++) d[8*i +: 8] = msg[k*IB + i];
         beat(d, 3'(rem > IB ? IB : rem), k == nb - 1);
      end
      in_valid = 1'b0;
      in_last = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while ((q.size() != 0 || blk_valid) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk("drain_queue", q.size(), 0);
   endtask

   task automatic rst_chk(input string tag);
      chk({tag, "_valid"}, blk_valid, 0);
      chk({tag, "_words"}, blk_words, 0);
      chk({tag, "_first"}, blk_first, 0);
      chk({tag, "_last"}, blk_last, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_in_ready"}, in_ready, 1);
   endtask

   task automatic pulse_reset(input string tag);
      #3 reset_n = 1'b0;
      #1 rst_chk(tag);
      @(negedge clk);
      #3 q.delete();
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      logic [32*RW-1:0] hw;
      logic hf, hl;
      bit held;
      blk_t e;
      held = 0;
      forever begin
         @(negedge clk);
         #1;
         if (!reset_n) begin
            held = 0;
            continue;
         end
         blk_ready = rdy_mode == 1 ? 1'b0 : rdy_mode == 2 ? 1'b1 : ($urandom_range(0, 2) != 0);
         if (held) begin
            chk("stall_valid", blk_valid, 1);
            chk("stall_words", blk_words, hw);
            chk("stall_flags", {blk_first, blk_last}, {hf, hl});
         end
         held = 0;
         if (blk_valid) chk("ready_while_valid", in_ready, 0);
         if (blk_valid && blk_ready) begin
            if (q.size() == 0) begin
               total++; bad++;
               $display("FAIL extra_block: got %h want none", blk_words);
            end else begin
               e = q.pop_front();
               chk("blk_words", blk_words, e.w);
               chk("blk_first", blk_first, e.f);
               chk("blk_last", blk_last, e.l);
            end
         end else if (blk_valid) begin
            held = 1;
            hw = blk_words; hf = blk_first; hl = blk_last;
         end
      end
   end

   initial begin
      logic [32*RW-1:0] va;
      repeat (2) @(negedge clk);
      #1 rst_chk("reset");
      reset_n = 1'b1;
      @(negedge clk);

      load_hello(); model();
      chk("pin_t1_count", q.size(), 1);
      chk("pin_t1_words", q[0].w, 256'h0_0_0_0_00210A06_6F726C64_6F2C2077_48656C6C);
      chk("pin_t1_flags", {q[0].f, q[0].l}, 2'b11);
      send(999, 0);

      drain();
      va = 256'hEA6F07F0_7821EB59_AC743D8E_FD5C99EB_A5D6D1C2_D86367D3_F3FD8315_21AB5F07;
      msg.delete();
      for (int w = 0; w < RW; w++) for (int k = 0; k < 4; k++) msg.push_back(va[32*w + 24 - 8*k +: 8]);
      model();
      chk("pin_t2_count", q.size(), 2);
      chk("pin_t2_a", q[0].w, va);
      chk("pin_t2_b", q[1].w, 256'h6);
      chk("pin_t2_flags", {q[0].f, q[0].l, q[1].f, q[1].l}, 4'b1001);
      send(999, 0);

      drain();
      msg.delete(); model();
      chk("pin_t3_words", q[0].w, 256'h6);
      chk("pin_t3_flags", {q[0].f, q[0].l}, 2'b11);
      send(999, 0);

      drain();
      rdy_mode = 1;
      load_hello(); model(); send(999, 0);
      chk("t4_latency", blk_valid, 1);
      hold_w = blk_words;
      repeat (5) begin
         @(negedge clk);
         chk("t4_in_ready", in_ready, 0);
         chk("t4_words", blk_words, hold_w);
      end
      rdy_mode = 2;
      @(negedge clk);
      @(negedge clk);
      chk("t4_release", in_ready, 1);
      load_hello(); model(); send(999, 0);
      rdy_mode = 0;

      for (int m = 0; m < 30; m++) begin
         msg.delete();
         repeat ($urandom_range(0, 80)) msg.push_back(8'($urandom));
         model(); send(999, 0);
      end
      drain();
      chk("no_err", err, 0);

      msg.delete();
      repeat ($urandom_range(20, 60)) msg.push_back(8'($urandom));
      model(); send(999, 1);
      chk("t5_err", err, 1);
      for (int m = 0; m < 10; m++) begin
         msg.delete();
         repeat ($urandom_range(0, 70)) msg.push_back(8'($urandom));
         model(); send(999, $urandom_range(0, 1));
      end
      drain();
      chk("t5_err_sticky", err, 1);

      load_hello(); send(2, 0);
      pulse_reset("t6_mid");
      load_hello(); model(); send(999, 0);
      drain();

      rdy_mode = 1;
      load_hello(); model(); send(999, 0);
      chk("t6_hold_valid", blk_valid, 1);
      pulse_reset("t6_hold");
      rdy_mode = 0;
      load_hello(); model(); send(999, 0);
      drain();
      chk("t6_err", err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
